pitch_scheduler: RTL and testbench

- Time-multiplexes one shared note→phase-increment constant mapper (9-bit sound index in, 24-bit constant out, purely combinational) across VOICES oscillator voices.
- Holds per-voice note numbers and applies a global transpose.
- Tracks which voices need recomputation, feeds the mapper one voice at a time, and writes results into the oscillator phase-increment table.
- Sits between the MIDI/voice-allocation logic and the oscillator bank.

---
 rtl/pitch_sched_pkg.sv | 30 +++
 rtl/pitch_sched_rr_pick.sv | 34 +++
 rtl/pitch_scheduler.sv | 148 ++++++++++++++
 tb/tb_pitch_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_sched_pkg.sv
// pitch_sched_pkg: shared types, widths and the sound-index clamp for the
// pitch scheduler.
//   state_e     - scheduler FSM states (PICK, LOOKUP)
//   SOUND_MAX   - default upper clamp for the mapper sound index
//   NOTE_W / SOUND_W / CONST_W - note, sound index and constant widths
//   clamp_sound - saturates a signed note+transpose sum into [0, smax]
package pitch_sched_pkg;

    typedef enum logic {
        PICK   = 1'b0,
        LOOKUP = 1'b1
    } state_e;

    localparam int NOTE_W    = 8;
    localparam int SOUND_W   = 9;
    localparam int CONST_W   = 24;
    localparam int SOUND_MAX = 311;

    // note (0..255) + transpose (-128..127) always fits a signed 10-bit value.
    function automatic logic [SOUND_W-1:0] clamp_sound(input logic signed [9:0]  s,
                                                       input logic [SOUND_W-1:0] smax);
        if (s < 0)
            return '0;
        else if (s > $signed({1'b0, smax}))
            return smax;
        else
            return s[SOUND_W-1:0];
    endfunction

endpackage

// File: rtl/pitch_sched_rr_pick.sv
// pitch_sched_rr_pick: combinational round-robin first-set finder.
// Returns the first set bit of dirty_i at or after ptr_i, wrapping modulo
// VOICES (VOICES must be a power of two so the V_WIDTH-bit add wraps).
//   dirty_i [VOICES]  - per-voice recompute requests
//   ptr_i   [V_WIDTH] - search start position
//   found_o           - any request pending
//   idx_o   [V_WIDTH] - selected voice (0 when nothing is found)
module pitch_sched_rr_pick #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3
) (
    input  logic [VOICES-1:0]  dirty_i,
    input  logic [V_WIDTH-1:0] ptr_i,
    output logic               found_o,
    output logic [V_WIDTH-1:0] idx_o
);
    import pitch_sched_pkg::*;

    logic [V_WIDTH-1:0] cand;

    assign found_o = |dirty_i;

    // Scan from the farthest offset down so the nearest hit is the last write.
    always_comb begin
        idx_o = '0;
        cand  = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            cand = ptr_i + V_WIDTH'(i);
            if (dirty_i[cand])
                idx_o = cand;
        end
    end

endmodule

// File: rtl/pitch_scheduler.sv
// pitch_scheduler: time-multiplexes one combinational note->phase-increment
// mapper across VOICES oscillator voices.
// Holds the per-voice notes and a global transpose, tracks which voices are
// dirty, and services them round-robin at one voice per two cycles: PICK
// drives the mapper index, LOOKUP captures the mapper result and writes it
// into the oscillator phase-increment table.
//   sCLK_XVXENVS - clock            reset      - synchronous, active high
//   note_wr/note_voice/note_num     - per-voice note write (always accepted)
//   transpose    - signed semitone offset, sampled every cycle
//   sound        - registered index to the shared mapper
//   constant     - mapper result for sound
//   inc_we/inc_addr/inc_data        - phase-table write port
//   busy         - any voice dirty or a lookup in flight
// Optional: define PITCH_SCHED_PERIODIC_REFRESH_EN to re-dirty every voice
// after REFRESH_IDLE idle cycles, scrubbing any table corruption.
module pitch_scheduler #(
    parameter int VOICES       = 8,
    parameter int V_WIDTH      = 3,
    parameter int SOUND_MAX    = pitch_sched_pkg::SOUND_MAX,
    parameter int REFRESH_IDLE = 1024
) (
    input  logic                sCLK_XVXENVS,
    input  logic                reset,
    input  logic                note_wr,
    input  logic [V_WIDTH-1:0]  note_voice,
    input  logic [7:0]          note_num,
    input  logic [7:0]          transpose,
    output logic [8:0]          sound,
    input  logic [23:0]         constant,
    output logic                inc_we,
    output logic [V_WIDTH-1:0]  inc_addr,
    output logic [23:0]         inc_data,
    output logic                busy
);
    import pitch_sched_pkg::*;

    logic [VOICES-1:0][NOTE_W-1:0] note_q;
    logic [VOICES-1:0]             dirty_q, dirty_d;
    logic [V_WIDTH-1:0]            rr_q;
    state_e                        state_q;
    logic [7:0]                    xpose_q;
    logic [SOUND_W-1:0]            sound_q;
    logic [V_WIDTH-1:0]            inc_addr_q;
    logic [CONST_W-1:0]            inc_data_q;
    logic                          inc_we_q;
    logic                          busy_q, busy_d;

    logic                          found;
    logic [V_WIDTH-1:0]            pick_idx;
    logic                          pick_fire;
    logic signed [9:0]             s_sum;
    logic [SOUND_W-1:0]            pick_sound;
    logic                          refresh_hit;

    pitch_sched_rr_pick #(
        .VOICES  (VOICES),
        .V_WIDTH (V_WIDTH)
    ) u_pick (
        .dirty_i (dirty_q),
        .ptr_i   (rr_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    assign pick_fire  = (state_q == PICK) && found;
    assign s_sum      = $signed({2'b00, note_q[pick_idx]}) + $signed({{2{xpose_q[7]}}, xpose_q});
    assign pick_sound = clamp_sound(s_sum, SOUND_W'(SOUND_MAX));

    // Sets are applied after the PICK clear so a write landing on the voice
    // being picked gets serviced again with the latest note.
    always_comb begin
        dirty_d = dirty_q;
        if (pick_fire)
            dirty_d[pick_idx] = 1'b0;
        if (note_wr)
            dirty_d[note_voice] = 1'b1;
        if (transpose != xpose_q || refresh_hit)
            dirty_d = '1;
    end

    // busy is the OR of the next-cycle dirty/LOOKUP/inc_we, registered so it
    // lines up with those registers and reads 0 while reset is held.
    assign busy_d = (|dirty_d) | pick_fire | (state_q == LOOKUP);

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset) begin
            note_q     <= '0;
            dirty_q    <= '1;
            rr_q       <= '0;
            state_q    <= PICK;
            xpose_q    <= '0;
            sound_q    <= '0;
            inc_addr_q <= '0;
            inc_data_q <= '0;
            inc_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (note_wr)
                note_q[note_voice] <= note_num;
            dirty_q  <= dirty_d;
            xpose_q  <= transpose;
            busy_q   <= busy_d;
            inc_we_q <= 1'b0;
            case (state_q)
                PICK: begin
                    if (found) begin
                        sound_q    <= pick_sound;
                        inc_addr_q <= pick_idx;
                        state_q    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    inc_data_q <= constant;
                    inc_we_q   <= 1'b1;
                    rr_q       <= inc_addr_q + V_WIDTH'(1);
                    state_q    <= PICK;
                end
                default: state_q <= PICK;
            endcase
        end
    end

`ifdef PITCH_SCHED_PERIODIC_REFRESH_EN
    localparam int IDLE_W = $clog2(REFRESH_IDLE);
    logic [IDLE_W-1:0] idle_q;

    assign refresh_hit = !busy_q && (idle_q == IDLE_W'(REFRESH_IDLE - 1));

    always_ff @(posedge sCLK_XVXENVS) begin
        if (reset || busy_q || refresh_hit)
            idle_q <= '0;
        else
            idle_q <= idle_q + IDLE_W'(1);
    end
`else
    // Refresh disabled: the table only changes on reset, note or transpose.
    assign refresh_hit = 1'b0;
    logic unused_refresh_cfg;
    assign unused_refresh_cfg = (REFRESH_IDLE != 0);
`endif

    assign sound    = sound_q;
    assign inc_we   = inc_we_q;
    assign inc_addr = inc_addr_q;
    assign inc_data = inc_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pitch_scheduler.sv
// Scoreboard bench for pitch_scheduler: directed stimulus pushes expected
// (addr, sound, data) table writes; a negedge monitor pops and compares on
// every inc_we. The mapper is modelled here as a semitone table shifted by
// octave (sound 0 -> 2608>>10).
module tb_pitch_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        note_wr = 1'b0;
    logic [2:0]  note_voice = '0;
    logic [7:0]  note_num = '0;
    logic [7:0]  transpose = '0;
    logic [8:0]  sound;
    logic [23:0] constant;
    logic        inc_we;
    logic [2:0]  inc_addr;
    logic [23:0] inc_data;
    logic        busy;

    always #5 clk = ~clk;

    pitch_scheduler dut (
        .sCLK_XVXENVS (clk),
        .reset        (reset),
        .note_wr      (note_wr),
        .note_voice   (note_voice),
        .note_num     (note_num),
        .transpose    (transpose),
        .sound        (sound),
        .constant     (constant),
        .inc_we       (inc_we),
        .inc_addr     (inc_addr),
        .inc_data     (inc_data),
        .busy         (busy)
    );

    function automatic logic [23:0] mapper(input logic [8:0] s);
        int unsigned base;
        logic [63:0] v;
        case (int'(s) % 12)
            0: base = 2608;  1: base = 2763;  2: base = 2927;  3: base = 3101;
            4: base = 3286;  5: base = 3481;  6: base = 3688;  7: base = 3907;
            8: base = 4140;  9: base = 4386; 10: base = 4647; default: base = 4923;
        endcase
        v = 64'(base) << (int'(s) / 12);
        return v[33:10];
    endfunction

    assign constant = mapper(sound);

    typedef struct {
        logic [2:0]  addr;
        logic [8:0]  snd;
        logic [23:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   last_we_cyc = 0;
    logic prev_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [2:0] a, input logic [8:0] s, input logic [23:0] d);
        exp_t e;
        e.addr = a; e.snd = s; e.data = d;
        sb.push_back(e);
    endfunction

    // Monitor: every table write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (inc_we === 1'b1) begin
            wr_cnt++;
            last_we_cyc = cyc;
            check("we_single_pulse", {31'b0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, no write expected", inc_addr, inc_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr",  {29'b0, inc_addr}, {29'b0, e.addr});
                check("wr_sound", {23'b0, sound},    {23'b0, e.snd});
                check("wr_data",  {8'b0, inc_data},  {8'b0, e.data});
            end
        end
        prev_we = inc_we;
    end

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= bound) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: %0d writes still pending after %0d cycles", name, sb.size(), bound);
        end
    endtask

    initial begin
        int t0, n, w0;
        logic [2:0] v;

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check("rst_sound",    {23'b0, sound},    0);
        check("rst_inc_we",   {31'b0, inc_we},   0);
        check("rst_inc_addr", {29'b0, inc_addr}, 0);
        check("rst_inc_data", {8'b0, inc_data},  0);
        check("rst_busy",     {31'b0, busy},     0);

        // Post-reset sweep: all notes 0 -> sound 0, data 2, 16 cycles total.
        for (int i = 0; i < 8; i++) push(3'(i), 9'd0, 24'd2);
        t0 = cyc;
        reset = 1'b0;
        wait_idle("reset_sweep", 100);
        check("sweep_len", last_we_cyc - t0, 16);
        check("idle_busy", {31'b0, busy}, 0);

        // Single note write: latency and value.
        push(3'd3, 9'd125, 24'd3481);
        note_voice = 3'd3; note_num = 8'd125; note_wr = 1'b1;
        @(posedge clk); #1;
        note_wr = 1'b0;
        n = 0;
        while (inc_we !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("note_latency", n, 2);
        wait_idle("note_write", 50);

        // Transpose +12: all voices rewritten starting at rr=4.
        for (int i = 0; i < 8; i++) begin
            v = 3'(4 + i);
            if (v == 3'd3) push(v, 9'd137, 24'd6962);
            else           push(v, 9'd12,  24'd5);
        end
        transpose = 8'd12;
        wait_idle("xpose12", 100);

        // Transpose +100 and v5=250 together: v5 clamps to 311.
        for (int i = 0; i < 8; i++) begin
            v = 3'(4 + i);
            if (v == 3'd5)      push(v, 9'd311, mapper(9'd311));
            else if (v == 3'd3) push(v, 9'd225, mapper(9'd225));
            else                push(v, 9'd100, mapper(9'd100));
        end
        transpose = 8'd100; note_voice = 3'd5; note_num = 8'd250; note_wr = 1'b1;
        @(posedge clk); #1;
        note_wr = 1'b0;
        wait_idle("clamp_hi", 100);

        // Transpose -20 and v5=0: negative sums clamp to 0.
        for (int i = 0; i < 8; i++) begin
            v = 3'(4 + i);
            if (v == 3'd3) push(v, 9'd105, mapper(9'd105));
            else           push(v, 9'd0,   24'd2);
        end
        transpose = 8'hEC; note_voice = 3'd5; note_num = 8'd0; note_wr = 1'b1;
        @(posedge clk); #1;
        note_wr = 1'b0;
        wait_idle("clamp_lo", 100);

        // v2 rewritten in the cycle PICK selects it: two writes, latest last.
        push(3'd2, 9'd40, mapper(9'd40));
        push(3'd2, 9'd52, mapper(9'd52));
        note_voice = 3'd2; note_num = 8'd60; note_wr = 1'b1;
        @(posedge clk); #1;
        note_num = 8'd72;
        @(posedge clk); #1;
        note_wr = 1'b0;
        wait_idle("set_wins", 50);

        // Long idle window.
`ifdef PITCH_SCHED_PERIODIC_REFRESH_EN
        for (int i = 0; i < 8; i++) begin
            v = 3'(3 + i);
            if (v == 3'd3)      push(v, 9'd105, mapper(9'd105));
            else if (v == 3'd2) push(v, 9'd52,  mapper(9'd52));
            else                push(v, 9'd0,   24'd2);
        end
        wait_idle("refresh", 1300);
`else
        w0 = wr_cnt;
        repeat (1100) @(posedge clk);
        #1;
        check("no_refresh_writes", wr_cnt, w0);
`endif

        // Reset while a lookup is in flight: the write is dropped.
        note_voice = 3'd3; note_num = 8'd99; note_wr = 1'b1;
        @(posedge clk); #1;
        note_wr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; transpose = 8'd0;
        @(posedge clk); #1;
        check("midrst_inc_we",   {31'b0, inc_we},   0);
        check("midrst_sound",    {23'b0, sound},    0);
        check("midrst_inc_addr", {29'b0, inc_addr}, 0);
        check("midrst_busy",     {31'b0, busy},     0);
        for (int i = 0; i < 8; i++) push(3'(i), 9'd0, 24'd2);
        reset = 1'b0;
        wait_idle("midrst_sweep", 100);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
